// File: rtl/fir_stream_source.sv
// Host-to-FIR transmit front end: buffers samples in a small FIFO and drives the FIR stream,
// and sequences a full coefficient reload once the sample stream has drained.
module fir_stream_source #(
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COEF_WORDS = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  input  logic              host_is_coeff,
  output logic              host_ready,
  output logic [DATA_W-1:0] m_axis_fir_tdata,
  output logic              m_axis_fir_tvalid,
  input  logic              m_axis_fir_tready,
  output logic              m_set_coeffs,
  output logic              load_done,
  output logic [CNT_W-1:0]  sample_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = (COEF_WORDS > 1) ? $clog2(COEF_WORDS) : 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(COEF_WORDS - 1);

  typedef enum logic [1:0] {StStream, StDrain, StLoad} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  shadow_q [COEF_WORDS];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [IdxW-1:0]    coef_idx_q, coef_idx_d;
  logic               tvalid_q, load_done_q;
  logic [CNT_W-1:0]   sample_count_q;
  logic               fifo_full, push, pop, coef_wr, enter_load, leave_load;

  assign fifo_full  = (count_q == FullCnt);
  assign host_ready = !reset && (state_q == StStream) && !fifo_full;
  assign push       = host_valid && host_ready && !host_is_coeff;
  assign coef_wr    = host_valid && host_ready && host_is_coeff;
  assign pop        = tvalid_q && m_axis_fir_tready;

  // FIFO occupancy next-state; simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Mode sequencing: collect coefficients, wait for an empty stream, then replay the shadow words
  always_comb begin
    state_d    = state_q;
    coef_idx_d = coef_idx_q;
    enter_load = 1'b0;
    leave_load = 1'b0;
    unique case (state_q)
      StStream: begin
        if (coef_wr) begin
          if (coef_idx_q == LastIdx) begin
            state_d    = StDrain;
            coef_idx_d = '0;
          end else begin
            coef_idx_d = coef_idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!tvalid_q && (count_q == '0)) begin
          state_d    = StLoad;
          enter_load = 1'b1;
        end
      end
      StLoad: begin
        if (coef_idx_q == LastIdx) begin
          state_d    = StStream;
          coef_idx_d = '0;
          leave_load = 1'b1;
        end else begin
          coef_idx_d = coef_idx_q + 1'b1;
        end
      end
      default: begin
        state_d    = StStream;
        coef_idx_d = '0;
      end
    endcase
  end

  // Control state, FIFO pointers, registered stream valid and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StStream;
      coef_idx_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      tvalid_q       <= 1'b0;
      load_done_q    <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q     <= state_d;
      coef_idx_q  <= coef_idx_d;
      count_q     <= count_d;
      // valid follows occupancy one cycle later, so it only drops after the last word leaves
      tvalid_q    <= (count_d != '0);
      load_done_q <= leave_load;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (enter_load) begin
        sample_count_q <= '0;
      end else if (pop && (sample_count_q != '1)) begin
        sample_count_q <= sample_count_q + 1'b1;
      end
    end
  end

  // Coefficient shadow registers filled from the host in order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COEF_WORDS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (coef_wr) begin
      shadow_q[coef_idx_q] <= host_data;
    end
  end

  // Sample storage; occupancy alone decides which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= host_data;
    end
  end

  // Output data mux: shadow word while loading, FIFO head while valid, otherwise zero
  always_comb begin
    m_axis_fir_tdata = '0;
    if (state_q == StLoad) begin
      m_axis_fir_tdata = shadow_q[coef_idx_q];
    end else if (tvalid_q) begin
      m_axis_fir_tdata = fifo_q[rd_ptr_q];
    end
  end

  assign m_axis_fir_tvalid = tvalid_q;
  assign m_set_coeffs      = (state_q == StLoad);
  assign load_done         = load_done_q;
  assign sample_count      = sample_count_q;

endmodule

// File: tb/tb_fir_stream_source.sv
// Bench for fir_stream_source: directed scenarios plus random traffic against a queue model.
module tb_fir_stream_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  host_data = '0;
  logic        host_valid = 1'b0;
  logic        host_is_coeff = 1'b0;
  logic        host_ready;
  logic [5:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        set_coeffs;
  logic        load_done;
  logic [15:0] sample_count;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model: mode 0 stream, 1 drain, 2 load
  logic [5:0]  mq[$];
  logic [5:0]  msh [3];
  int          mmode = 0;
  int          mcidx = 0;
  int          mlpos = 0;
  logic [15:0] mcnt = '0;
  bit          mdone = 1'b0;
  int          sz0, m0;
  bit          rdy0;

  fir_stream_source dut (
    .clk               (clk),
    .reset             (reset),
    .host_data         (host_data),
    .host_valid        (host_valid),
    .host_is_coeff     (host_is_coeff),
    .host_ready        (host_ready),
    .m_axis_fir_tdata  (tdata),
    .m_axis_fir_tvalid (tvalid),
    .m_axis_fir_tready (tready),
    .m_set_coeffs      (set_coeffs),
    .load_done         (load_done),
    .sample_count      (sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mmode = 0;
    mcidx = 0;
    mlpos = 0;
    mcnt  = '0;
    mdone = 1'b0;
  endtask

  // Model advance on each rising edge from the inputs presented before it
  initial forever begin
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      sz0   = mq.size();
      m0    = mmode;
      rdy0  = (m0 == 0) && (sz0 < 4);
      mdone = 1'b0;
      if (sz0 > 0 && tready) begin
        void'(mq.pop_front());
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
      if (host_valid && rdy0) begin
        if (!host_is_coeff) begin
          mq.push_back(host_data);
        end else begin
          msh[mcidx] = host_data;
          if (mcidx == 2) begin
            mmode = 1;
            mcidx = 0;
          end else begin
            mcidx++;
          end
        end
      end
      if (m0 == 1 && sz0 == 0) begin
        mmode = 2;
        mlpos = 0;
        mcnt  = '0;
      end else if (m0 == 2) begin
        if (mlpos == 2) begin
          mmode = 0;
          mdone = 1'b1;
        end else begin
          mlpos++;
        end
      end
    end
  end

  // Compare every DUT output against the model on the falling edge
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("host_ready", int'(host_ready), int'(!reset && mmode == 0 && mq.size() < 4));
      chk("tvalid", int'(tvalid), int'(mq.size() > 0));
      if (mmode == 2) chk("tdata_load", int'(tdata), int'(msh[mlpos]));
      else if (mq.size() > 0) chk("tdata_stream", int'(tdata), int'(mq[0]));
      else chk("tdata_idle", int'(tdata), 0);
      chk("set_coeffs", int'(set_coeffs), int'(mmode == 2));
      chk("load_done", int'(load_done), int'(mdone));
      chk("sample_count", int'(sample_count), int'(mcnt));
    end
  end

  // Present inputs, then return just after the following falling edge
  task automatic step(input bit v, input bit c, input logic [5:0] d, input bit r);
    host_valid    = v;
    host_is_coeff = c;
    host_data     = d;
    tready        = r;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_load(input string name);
    int n = 0;
    while (!set_coeffs && n < 10) begin
      step(1'b0, 1'b0, 6'h00, 1'b0);
      n++;
    end
    if (!set_coeffs) chk(name, int'(set_coeffs), 1);
  endtask

  logic [5:0] c3 [3];
  int idx;
  int nwait;

  initial begin
    c3[0] = 6'h11;
    c3[1] = 6'h22;
    c3[2] = 6'h33;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", int'(host_ready), 0);
    chk("reset_tvalid", int'(tvalid), 0);
    chk("reset_tdata", int'(tdata), 0);
    reset = 1'b0;
    #1;
    check_en = 1'b1;
    chk("reset_count", int'(sample_count), 0);
    chk("release_ready", int'(host_ready), 1);

    // 1: single sample, one-cycle latency
    step(1'b1, 1'b0, 6'h05, 1'b1);
    chk("t1_tvalid", int'(tvalid), 1);
    chk("t1_tdata", int'(tdata), 'h05);
    step(1'b0, 1'b0, 6'h00, 1'b1);
    chk("t1_drop", int'(tvalid), 0);
    chk("t1_count", int'(sample_count), 1);

    // 2: fill to full, fifth word refused, then burst out
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 6'(i), 1'b0);
    chk("t2_full_ready", int'(host_ready), 0);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", int'(tdata), i);
      step(1'b0, 1'b0, 6'h00, 1'b1);
    end
    chk("t2_empty", int'(tvalid), 0);
    chk("t2_count", int'(sample_count), 5);

    // 3: reload with two samples pending
    step(1'b1, 1'b0, 6'h0A, 1'b0);
    step(1'b1, 1'b0, 6'h0B, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, c3[k], 1'b0);
    chk("t3_drain_ready", int'(host_ready), 0);
    step(1'b0, 1'b0, 6'h00, 1'b0);
    step(1'b0, 1'b0, 6'h00, 1'b0);
    chk("t3_no_early_load", int'(set_coeffs), 0);
    step(1'b0, 1'b0, 6'h00, 1'b1);
    step(1'b0, 1'b0, 6'h00, 1'b1);
    chk("t3_drained_count", int'(sample_count), 7);
    chk("t3_still_drain", int'(set_coeffs), 0);
    nwait = 0;
    while (!set_coeffs && nwait < 10) begin
      step(1'b0, 1'b0, 6'h00, 1'b0);
      nwait++;
    end
    chk("t3_load_latency", nwait, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t3_set", int'(set_coeffs), 1);
      chk("t3_load_tvalid", int'(tvalid), 0);
      chk("t3_load_word", int'(tdata), int'(c3[k]));
      step(1'b0, 1'b0, 6'h00, 1'b0);
    end
    chk("t3_done", int'(load_done), 1);
    chk("t3_set_off", int'(set_coeffs), 0);
    chk("t3_count_clr", int'(sample_count), 0);
    step(1'b0, 1'b0, 6'h00, 1'b0);
    chk("t3_done_pulse", int'(load_done), 0);

    // 4: reset during the second load cycle
    step(1'b1, 1'b1, 6'h21, 1'b0);
    step(1'b1, 1'b1, 6'h12, 1'b0);
    step(1'b1, 1'b1, 6'h3F, 1'b0);
    wait_load("t4_load_start");
    step(1'b0, 1'b0, 6'h00, 1'b0);
    chk("t4_second_word", int'(tdata), 'h12);
    reset = 1'b1;
    #1;
    chk("t4_set_async", int'(set_coeffs), 0);
    chk("t4_tvalid_async", int'(tvalid), 0);
    chk("t4_tdata_async", int'(tdata), 0);
    chk("t4_ready_in_reset", int'(host_ready), 0);
    step(1'b0, 1'b0, 6'h00, 1'b0);
    reset = 1'b0;
    #1;
    chk("t4_ready_after", int'(host_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 6'h00, 1'b0);
      chk("t4_no_done", int'(load_done), 0);
    end

    // 5: alternating tready stalls
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'(6'h31 + i), 1'b0);
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        chk("t5_seq", int'(tdata), 'h31 + idx);
        idx++;
      end
      step(1'b0, 1'b0, 6'h00, 1'(i % 2 == 0));
    end
    chk("t5_empty", int'(tvalid), 0);
    chk("t5_count", int'(sample_count), 4);

    // 6: push and pop together at occupancy 3
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 6'(i), 1'b0);
    step(1'b1, 1'b0, 6'h04, 1'b1);
    chk("t6_ready_occ3", int'(host_ready), 1);
    chk("t6_head", int'(tdata), 2);
    step(1'b1, 1'b0, 6'h05, 1'b0);
    chk("t6_full", int'(host_ready), 0);
    for (int v = 2; v <= 5; v++) begin
      chk("t6_order", int'(tdata), v);
      step(1'b0, 1'b0, 6'h00, 1'b1);
    end
    chk("t6_empty", int'(tvalid), 0);

    // Random traffic, including occasional coefficient reloads
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0), 6'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    // Let any in-flight reload complete
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 6'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
